// File: rtl/biu_n.sv
// N-slave bus interface unit: decodes core requests against base/mask windows,
// forwards them to one slave and returns registered data, or an error on miss/timeout.
module biu_n_dec #(
    parameter logic [31:0] BASE = 32'h0,
    parameter logic [31:0] MASK = 32'h0
) (
    input  logic [31:0] addr,
    output logic        hit
);
    assign hit = ((addr & MASK) == BASE);
endmodule

module biu_n #(
    parameter int                   NSLV     = 3,
    parameter logic [32*NSLV-1:0]   SLV_BASE = {32'h00010000, 32'h00034564, 32'h00000000},
    parameter logic [32*NSLV-1:0]   SLV_MASK = {32'hFFFF0000, 32'hFFFFFFFF, 32'hFFF00000},
    parameter int                   TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          daddr,
    input  logic [31:0]          dwdata,
    input  logic [3:0]           dwe,
    input  logic                 dre,
    output logic [31:0]          drdata,
    output logic                 dready,
    output logic                 derr,
    output logic [31:0]          saddr,
    output logic [31:0]          swdata,
    output logic [4*NSLV-1:0]    swe,
    output logic [NSLV-1:0]      ssel,
    input  logic [32*NSLV-1:0]   srdata,
    input  logic [NSLV-1:0]      sready
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, nxt;
    logic [NSLV-1:0] hit;
    logic            any_hit;
    logic [IW-1:0]   hit_idx, idx_q;
    logic [NSLV-1:0] sel_q;
    logic [3:0]      we_q;
    logic [CW-1:0]   cnt;
    logic            derr_q;
    logic            req, ack, tmo;

    for (genvar g = 0; g < NSLV; g++) begin : g_dec
        biu_n_dec #(
            .BASE(SLV_BASE[32*g +: 32]),
            .MASK(SLV_MASK[32*g +: 32])
        ) u_dec (
            .addr(daddr),
            .hit (hit[g])
        );
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (hit[k]) begin
                any_hit = 1'b1;
                hit_idx = IW'(k);
            end
        end
    end

    assign req = dre | (|dwe);
    assign ack = sready[idx_q];
    assign tmo = (cnt == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req) nxt = any_hit ? WAIT : RESP;
            WAIT:    if (ack || tmo) nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        dready = (state == RESP);
        derr   = derr_q & (state == RESP);
        ssel   = sel_q;
        for (int k = 0; k < NSLV; k++)
            swe[4*k +: 4] = sel_q[k] ? we_q : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drdata <= '0;
            derr_q <= 1'b0;
            saddr  <= '0;
            swdata <= '0;
            we_q   <= '0;
            idx_q  <= '0;
            sel_q  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    if (any_hit) begin
                        saddr  <= daddr;
                        swdata <= dwdata;
                        we_q   <= dwe;
                        idx_q  <= hit_idx;
                        sel_q  <= NSLV'(1) << hit_idx;
                        cnt    <= '0;
                    end else begin
                        drdata <= '0;
                        derr_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        drdata <= srdata[32*idx_q +: 32];
                        derr_q <= 1'b0;
                        sel_q  <= '0;
                    end else if (tmo) begin
                        drdata <= '0;
                        derr_q <= 1'b1;
                        sel_q  <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
